// File: rtl/demux8_1x4_reg.sv
// Registered 1-to-4 demultiplexer: steers a valid/ready source stream into four
// independently drained holding registers and counts accepted words.
module demux8_1x4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       tx_count
);

    logic [WIDTH-1:0] data0_r;
    logic [WIDTH-1:0] data1_r;
    logic [WIDTH-1:0] data2_r;
    logic [WIDTH-1:0] data3_r;
    logic [3:0]       valid_r;
    logic [7:0]       count_r;

    logic             target_busy_s;
    logic             ready_s;
    logic             accept_s;
    logic [3:0]       load_s;
    logic [3:0]       drain_s;
    logic [3:0]       valid_next_s;

    function automatic logic [3:0] decode_onehot(input logic [1:0] idx);
        logic [3:0] result;
        case (idx)
            2'd0:    result = 4'b0001;
            2'd1:    result = 4'b0010;
            2'd2:    result = 4'b0100;
            2'd3:    result = 4'b1000;
            default: result = 4'b0000;
        endcase
        return result;
    endfunction

    // Handshake decode: a port being drained this cycle counts as free for reload.
    always_comb begin
        target_busy_s = 1'b0;
        ready_s       = 1'b0;
        accept_s      = 1'b0;
        load_s        = 4'b0000;
        drain_s       = 4'b0000;
        valid_next_s  = valid_r;

        target_busy_s = valid_r[select] & ~out_ready[select];
        ready_s       = reset_n & ~clear & ~target_busy_s;
        accept_s      = in_valid & ready_s;
        drain_s       = valid_r & out_ready;

        if (accept_s) begin
            load_s = decode_onehot(select);
        end else begin
            load_s = 4'b0000;
        end

        if (clear) begin
            valid_next_s = 4'b0000;
        end else begin
            valid_next_s = (valid_r & ~drain_s) | load_s;
        end
    end

    // Valid flags and accepted-word counter; clear flushes flags only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 4'b0000;
            count_r <= 8'd0;
        end else begin
            valid_r <= valid_next_s;
            if (accept_s) begin
                count_r <= count_r + 8'd1;
            end
        end
    end

    // Holding registers keep their last word after drain or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data0_r <= '0;
            data1_r <= '0;
            data2_r <= '0;
            data3_r <= '0;
        end else begin
            if (load_s[0]) data0_r <= in_data;
            if (load_s[1]) data1_r <= in_data;
            if (load_s[2]) data2_r <= in_data;
            if (load_s[3]) data3_r <= in_data;
        end
    end

    assign in_ready  = ready_s;
    assign out_data0 = data0_r;
    assign out_data1 = data1_r;
    assign out_data2 = data2_r;
    assign out_data3 = data3_r;
    assign out_valid = valid_r;
    assign tx_count  = count_r;

endmodule

// File: tb/tb_demux8_1x4_reg.sv
// Directed self-checking bench for demux8_1x4_reg; inputs change on the falling
// edge and outputs are sampled on the falling edge or shortly after it.
module tb_demux8_1x4_reg;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic [1:0] select;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] tx_count;

    int checks;
    int errors;

    demux8_1x4_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_count  (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        select    = 2'd0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Power-on reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data0", 32'(out_data0), 32'h0);
        chk("rst_count", 32'(tx_count), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", 32'(in_ready), 32'h1);

        // Basic steer to port 2
        @(negedge clk);
        select = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b0000;
        #1 chk("steer_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        chk("steer_lat0", 32'(out_valid), 32'h4);
        in_valid = 1'b0;
        chk("steer_data2", 32'(out_data2), 32'hA5);
        chk("steer_count", 32'(tx_count), 32'h1);
        chk("steer_data0", 32'(out_data0), 32'h0);
        chk("steer_data1", 32'(out_data1), 32'h0);
        chk("steer_data3", 32'(out_data3), 32'h0);

        // Backpressure on port 1
        select = 2'd1; in_data = 8'h3C; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_load_valid", 32'(out_valid), 32'h6);
        chk("bp_load_count", 32'(tx_count), 32'h2);
        select = 2'd1; in_data = 8'h77; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_stall_ready", 32'(in_ready), 32'h0);
            chk("bp_stall_data1", 32'(out_data1), 32'h3C);
            @(negedge clk);
        end
        chk("bp_stall_count", 32'(tx_count), 32'h2);
        out_ready = 4'b0010;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("bp_data1", 32'(out_data1), 32'h77);
        chk("bp_valid", 32'(out_valid), 32'h6);
        chk("bp_count", 32'(tx_count), 32'h3);

        // Load port 0, then drain all while loading port 3
        select = 2'd0; in_data = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        chk("sim_pre_valid", 32'(out_valid), 32'h7);
        select = 2'd3; in_data = 8'h0F; out_ready = 4'b1111;
        #1 chk("sim_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("sim_valid", 32'(out_valid), 32'h8);
        chk("sim_data3", 32'(out_data3), 32'h0F);
        chk("sim_data0", 32'(out_data0), 32'h11);
        chk("sim_data1", 32'(out_data1), 32'h77);
        chk("sim_data2", 32'(out_data2), 32'hA5);
        chk("sim_count", 32'(tx_count), 32'h5);

        // Fill ports 0..2 so all four are valid
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            select  = 2'(k);
            in_data = 8'h21 + 8'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fill_valid", 32'(out_valid), 32'hF);
        chk("fill_count", 32'(tx_count), 32'h8);

        // Full-port stall holds data
        select = 2'd2; in_data = 8'hEE; in_valid = 1'b1;
        #1 chk("full_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("full_data2", 32'(out_data2), 32'h23);

        // Clear beats load
        clear = 1'b1; select = 2'd0; in_data = 8'h99; in_valid = 1'b1;
        #1 chk("clr_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'h0);
        chk("clr_count", 32'(tx_count), 32'h8);
        chk("clr_data0", 32'(out_data0), 32'h21);

        // Idle ready on empty ports has no effect
        out_ready = 4'b1111;
        @(negedge clk);
        out_ready = 4'b0000;
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset with ports 1 and 3 holding words
        in_valid = 1'b1;
        select = 2'd1; in_data = 8'h5A;
        @(negedge clk);
        select = 2'd3; in_data = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'hA);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data1", 32'(out_data1), 32'h0);
        chk("arst_data3", 32'(out_data3), 32'h0);
        chk("arst_count", 32'(tx_count), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 256 back-to-back accepts, rotating ports, all draining
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            select  = 2'(i % 4);
            in_data = 8'(i);
            #1;
            chk("wrap_ready", 32'(in_ready), 32'h1);
            if (i == 255) chk("wrap_count255", 32'(tx_count), 32'hFF);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("wrap_count", 32'(tx_count), 32'h0);
        chk("wrap_valid", 32'(out_valid), 32'h8);
        chk("wrap_data0", 32'(out_data0), 32'hFC);
        chk("wrap_data1", 32'(out_data1), 32'hFD);
        chk("wrap_data2", 32'(out_data2), 32'hFE);
        chk("wrap_data3", 32'(out_data3), 32'hFF);
        @(negedge clk);
        out_ready = 4'b0000;
        chk("wrap_drained", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
